// File: rtl/mem_access_ctrl_if.sv
// Bundle of request, response and byte-memory signals for the load/store controller.
// The slave modport is the controller's view; master is the core/memory side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: serialises byte/half/word requests into big-endian byte
// accesses on a registered byte-wide memory and assembles/extends load data.
module mem_access_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic              uns_q;
   logic [31:0]       data_q;
   logic [1:0]        cnt_q;
   logic              resp_err_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_d;
   logic [31:0]       resp_rdata_d;

   logic              accept;
   logic              issuing;
   logic [2:0]        req_bytes;
   logic [ADDR_W:0]   last_addr;
   logic              range_err;
   logic              req_err;
   logic [31:0]       store_aligned;
   logic [1:0]        last_idx;
   logic              last_byte;
   logic              capture_en;
   logic [31:0]       shifted_in;
   logic [31:0]       load_result;

   assign accept  = (state_q == IDLE) && bus.req_valid;
   assign issuing = (state_q == ISSUE);

   always_comb begin
      req_bytes = 3'd4;
      case (bus.req_size)
         2'b00:   req_bytes = 3'd1;
         2'b01:   req_bytes = 3'd2;
         default: req_bytes = 3'd4;
      endcase
   end

   // One extra bit keeps addr+N-1 from wrapping past zero, so a request near the
   // top of the address space is still seen as out of range.
   assign last_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_bytes - 3'd1);
   assign range_err = last_addr >= (ADDR_W+1)'(MEM_BYTES);

   assign req_err = (bus.req_size == 2'b11)
                  || ((bus.req_size == 2'b01) && bus.req_addr[0])
                  || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                  || range_err;

   // Store data is left-justified so the byte to send next is always [31:24].
   always_comb begin
      store_aligned = bus.req_wdata;
      case (bus.req_size)
         2'b00:   store_aligned = {bus.req_wdata[7:0], 24'h000000};
         2'b01:   store_aligned = {bus.req_wdata[15:0], 16'h0000};
         default: store_aligned = bus.req_wdata;
      endcase
   end

   always_comb begin
      last_idx = 2'd3;
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

   assign last_byte = (cnt_q == last_idx);

   // Read data lags its address by one cycle, so byte k arrives while byte k+1 is
   // being issued, and the final byte arrives in CAPTURE.
   assign capture_en = (issuing && !we_q && (cnt_q != 2'd0)) || (state_q == CAPTURE);
   assign shifted_in = {data_q[23:0], bus.mem_rdata};

   always_comb begin
      load_result = shifted_in;
      case (size_q)
         2'b00:   load_result = {{24{~uns_q & shifted_in[7]}}, shifted_in[7:0]};
         2'b01:   load_result = {{16{~uns_q & shifted_in[15]}}, shifted_in[15:0]};
         default: load_result = shifted_in;
      endcase
   end

   // Next-state logic and the value the response registers take on entry to RESP.
   always_comb begin
      state_d      = state_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_err) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (last_byte) begin
               if (we_q) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b0;
                  resp_rdata_d = 32'h0;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            state_d      = RESP;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_result;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and response registers; resp_err/resp_rdata hold until the next RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Request capture, byte counter and the shared store/load shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         size_q <= 2'b00;
         we_q   <= 1'b0;
         uns_q  <= 1'b0;
         data_q <= 32'h0;
         cnt_q  <= 2'd0;
      end else if (accept) begin
         addr_q <= bus.req_addr;
         size_q <= bus.req_size;
         we_q   <= bus.req_we;
         uns_q  <= bus.req_unsigned;
         data_q <= bus.req_we ? store_aligned : 32'h0;
         cnt_q  <= 2'd0;
      end else if (issuing) begin
         cnt_q <= cnt_q + 2'd1;
         if (we_q) begin
            data_q <= {data_q[23:0], 8'h00};
         end else if (capture_en) begin
            data_q <= shifted_in;
         end
      end else if (capture_en) begin
         data_q <= shifted_in;
      end
   end

   // Memory-side outputs are decoded from registered state only, so an
   // asynchronous reset drops them to zero immediately.
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_en     = issuing;
   assign bus.mem_we     = issuing && we_q;
   assign bus.mem_addr   = issuing ? (addr_q + ADDR_W'(cnt_q)) : '0;
   assign bus.mem_wdata  = (issuing && we_q) ? data_q[31:24] : 8'h00;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table-driven transactions against a
// registered byte memory model, plus handshake and mid-transaction reset sequences.
module tb_mem_access_ctrl;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic memClear = 1'b1;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_ctrl #(
      .ADDR_W(ADDR_W),
      .MEM_BYTES(1024)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Registered byte memory: read data appears the cycle after the access.
   logic [7:0] tbMem [0:1023];

   always @(posedge clk) begin
      if (memClear) begin
         for (int i = 0; i < 1024; i++) tbMem[i] <= 8'h00;
         bus.mem_rdata <= 8'h00;
      end else if (bus.mem_en) begin
         if (bus.mem_we) tbMem[bus.mem_addr[9:0]] <= bus.mem_wdata;
         else bus.mem_rdata <= tbMem[bus.mem_addr[9:0]];
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expErr;
      logic [31:0] expRdata;
      int          expCycle;
   } vec_t;

   vec_t vecs[$];

   int total = 0;
   int bad = 0;

   int          respCycle;
   logic        respErr;
   logic [31:0] respData;
   int          readyHigh;
   int          logCount;
   logic [31:0] logAddr [0:7];
   logic [7:0]  logData [0:7];
   logic        logWe   [0:7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void addVec(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic expErr, input logic [31:0] expRdata,
                                  input int expCycle);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.expErr = expErr; v.expRdata = expRdata; v.expCycle = expCycle;
      vecs.push_back(v);
   endfunction

   function automatic int sizeBytes(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Cycle 0 is the cycle right after the acceptance edge; sampled at negedges.
   task automatic waitResp();
      respCycle = -1;
      respErr   = 1'b0;
      respData  = 32'h0;
      readyHigh = 0;
      logCount  = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.req_ready) readyHigh++;
         if (bus.mem_en && logCount < 8) begin
            logAddr[logCount] = bus.mem_addr;
            logData[logCount] = bus.mem_wdata;
            logWe[logCount]   = bus.mem_we;
            logCount++;
         end
         if (bus.resp_valid) begin
            respCycle = c;
            respErr   = bus.resp_err;
            respData  = bus.resp_rdata;
            break;
         end
      end
   endtask

   task automatic driveReq(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
   endtask

   task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      driveReq(we, size, uns, addr, wdata);
      bus.req_valid = 1'b1;
      checkOutput({name, " ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      driveReq(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h5555_5555);
      waitResp();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t  v;
      string nm;
      int    n;
      int    quiet;
      logic [31:0] expByte;

      bus.req_valid = 1'b0;
      driveReq(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("rst resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("rst resp_rdata", bus.resp_rdata, 32'd0);
      checkOutput("rst mem_en", 32'(bus.mem_en), 32'd0);
      checkOutput("rst mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst mem_addr", bus.mem_addr, 32'd0);
      checkOutput("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rst = 1'b1;
      memClear = 1'b0;

      //      we    size   uns   addr          wdata          err   rdata          cycle
      addVec(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hA1B2_C3D4, 1'b0, 32'h0000_0000, 4);
      addVec(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hA1B2_C3D4, 5);
      addVec(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_0080, 1'b0, 32'h0000_0000, 1);
      addVec(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'hFFFF_FF01, 1'b0, 32'h0000_0000, 1);
      addVec(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_FF80, 2);
      addVec(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0080, 2);
      addVec(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_8001, 3);
      addVec(1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_8001, 3);
      addVec(1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h0000_0000, 0);
      addVec(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h0000_0000, 0);
      addVec(1'b0, 2'b10, 1'b0, 32'h0000_03FE, 32'h0,         1'b1, 32'h0000_0000, 0);
      addVec(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0000_0000, 5);
      addVec(1'b1, 2'b00, 1'b0, 32'h0000_03FF, 32'h0000_005A, 1'b0, 32'h0000_0000, 1);
      addVec(1'b0, 2'b00, 1'b0, 32'h0000_03FF, 32'h0,         1'b0, 32'h0000_005A, 2);
      addVec(1'b1, 2'b01, 1'b0, 32'h0000_0031, 32'h0000_BEEF, 1'b1, 32'h0000_0000, 0);
      addVec(1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_0000, 3);
      addVec(1'b1, 2'b01, 1'b0, 32'h0000_0030, 32'hABCD_1234, 1'b0, 32'h0000_0000, 2);
      addVec(1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_1234, 3);
      addVec(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 0);
      addVec(1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'h0000_0077, 1'b1, 32'h0000_0000, 0);
      addVec(1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0,         1'b0, 32'h0000_0001, 2);
      addVec(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_C3D4, 3);

      for (int i = 0; i < vecs.size(); i++) begin
         v  = vecs[i];
         nm = $sformatf("v%0d", i);
         applyStimulus(nm, v.we, v.size, v.uns, v.addr, v.wdata);
         checkOutput({nm, " cycle"}, 32'(respCycle), 32'(v.expCycle));
         checkOutput({nm, " err"}, 32'(respErr), 32'(v.expErr));
         checkOutput({nm, " rdata"}, respData, v.expRdata);
         checkOutput({nm, " ready_busy"}, 32'(readyHigh), 32'd0);
         n = v.expErr ? 0 : sizeBytes(v.size);
         checkOutput({nm, " nbytes"}, 32'(logCount), 32'(n));
         for (int k = 0; k < n && k < logCount; k++) begin
            checkOutput($sformatf("%s addr%0d", nm, k), logAddr[k], v.addr + 32'(k));
            checkOutput($sformatf("%s we%0d", nm, k), 32'(logWe[k]), 32'(v.we));
            if (v.we) begin
               expByte = (v.wdata >> (8 * (n - 1 - k))) & 32'hFF;
               checkOutput($sformatf("%s wbyte%0d", nm, k), 32'(logData[k]), expByte);
            end
         end
         @(negedge clk);
         checkOutput({nm, " idle_ready"}, 32'(bus.req_ready), 32'd1);
         checkOutput({nm, " pulse"}, 32'(bus.resp_valid), 32'd0);
         checkOutput({nm, " hold"}, bus.resp_rdata, v.expRdata);
      end

      // Handshake: req_valid held high while the request fields change mid-flight.
      @(negedge clk);
      driveReq(1'b1, 2'b10, 1'b0, 32'h0000_0050, 32'h1122_3344);
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      driveReq(1'b0, 2'b00, 1'b1, 32'h0000_0051, 32'h0);
      waitResp();
      checkOutput("hs1 cycle", 32'(respCycle), 32'd4);
      checkOutput("hs1 err", 32'(respErr), 32'd0);
      checkOutput("hs1 ready_busy", 32'(readyHigh), 32'd0);
      checkOutput("hs1 nbytes", 32'(logCount), 32'd4);
      for (int k = 0; k < 4 && k < logCount; k++) begin
         expByte = (32'h1122_3344 >> (8 * (3 - k))) & 32'hFF;
         checkOutput($sformatf("hs1 addr%0d", k), logAddr[k], 32'h50 + 32'(k));
         checkOutput($sformatf("hs1 wbyte%0d", k), 32'(logData[k]), expByte);
      end
      @(negedge clk);
      checkOutput("hs2 ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      waitResp();
      checkOutput("hs2 cycle", 32'(respCycle), 32'd2);
      checkOutput("hs2 rdata", respData, 32'h0000_0022);
      checkOutput("hs2 nbytes", 32'(logCount), 32'd1);

      // Mid-transaction reset during byte 2 of a word store.
      applyStimulus("pre1", 1'b1, 2'b10, 1'b0, 32'h0000_0060, 32'h0102_0304);
      applyStimulus("pre2", 1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0);
      checkOutput("pre2 rdata", respData, 32'h0102_0304);
      @(negedge clk);
      driveReq(1'b1, 2'b10, 1'b0, 32'h0000_0060, 32'hDEAD_BEEF);
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mid byte2 addr", bus.mem_addr, 32'h0000_0062);
      rst = 1'b0;
      #1;
      checkOutput("mid ready", 32'(bus.req_ready), 32'd1);
      checkOutput("mid resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("mid resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("mid resp_rdata", bus.resp_rdata, 32'd0);
      checkOutput("mid mem_en", 32'(bus.mem_en), 32'd0);
      checkOutput("mid mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("mid mem_addr", bus.mem_addr, 32'd0);
      checkOutput("mid mem_wdata", 32'(bus.mem_wdata), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      quiet = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.resp_valid || bus.mem_en) quiet++;
      end
      checkOutput("mid no_resp", 32'(quiet), 32'd0);
      checkOutput("mid mem60", 32'(tbMem[10'h060]), 32'h0000_00DE);
      checkOutput("mid mem61", 32'(tbMem[10'h061]), 32'h0000_00AD);
      checkOutput("mid mem62", 32'(tbMem[10'h062]), 32'h0000_0003);
      checkOutput("mid mem63", 32'(tbMem[10'h063]), 32'h0000_0004);
      applyStimulus("post", 1'b0, 2'b00, 1'b1, 32'h0000_0061, 32'h0);
      checkOutput("post cycle", 32'(respCycle), 32'd2);
      checkOutput("post rdata", respData, 32'h0000_00AD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
